// File: rtl/irq_dispatch.sv
// irq_dispatch: takes enabled, pending interrupts at instruction boundaries, vectors per cause, returns on ERET.
// Optional nested preemption with a 2-entry (cause, epc) stack when IRQ_DISPATCH_NESTED_EN is defined.

module irq_dispatch #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0180,
    parameter int          VEC_STRIDE = 16
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic [DATA_WIDTH-1:0] i_ctrl,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_boundary,
    input  logic                  i_eret,
    output logic                  o_stall,
    output logic                  o_redirect,
    output logic [ADDR_WIDTH-1:0] o_redirect_pc,
    output logic                  o_ctrl_we,
    output logic [DATA_WIDTH-1:0] o_ctrl_data,
    output logic [1:0]            o_cause,
    output logic [ADDR_WIDTH-1:0] o_epc,
    output logic                  o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_VECTOR,
        ST_HANDLER,
        ST_RETURN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] VEC_BASE_A = ADDR_WIDTH'(VEC_BASE);

    state_t                  state;
    logic [1:0]              cause;
    logic [ADDR_WIDTH-1:0]   epc;

    logic [3:0]              masked;
    logic                    req;
    logic [1:0]              req_cause;
    logic [DATA_WIDTH-1:0]   ctrl_wb;
    logic [ADDR_WIDTH-1:0]   vec_pc;

`ifdef IRQ_DISPATCH_NESTED_EN
    logic [1:0]            stk_cause [2];
    logic [ADDR_WIDTH-1:0] stk_epc   [2];
    logic [1:0]            depth;
    logic                  push_idx;
    logic                  pop_idx;

    assign push_idx = depth[0];
    assign pop_idx  = ~depth[0];
`endif

    assign o_cause = cause;
    assign o_epc   = epc;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        masked    = i_ctrl[11:8] & i_ctrl[3:0];
        req       = i_ctrl[15] & (|masked);
        req_cause = 2'd0;
        if (masked[3])      req_cause = 2'd3;
        else if (masked[2]) req_cause = 2'd2;
        else if (masked[1]) req_cause = 2'd1;
    end

    // Write-back word and redirect target are decoded from the live control word and latched registers.
    always_comb begin
        ctrl_wb     = i_ctrl;
        ctrl_wb[15] = 1'b0;
        case (cause)
            2'd0:    ctrl_wb[8]  = 1'b0;
            2'd1:    ctrl_wb[9]  = 1'b0;
            2'd2:    ctrl_wb[10] = 1'b0;
            default: ctrl_wb[11] = 1'b0;
        endcase
        o_ctrl_data = o_ctrl_we ? ctrl_wb : '0;

        vec_pc = VEC_BASE_A + ADDR_WIDTH'({30'd0, cause} * VEC_STRIDE);
        if (!o_redirect)
            o_redirect_pc = '0;
        else if (state == ST_RETURN)
            o_redirect_pc = epc;
        else
            o_redirect_pc = vec_pc;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state      <= ST_IDLE;
            cause      <= 2'd0;
            epc        <= '0;
            o_stall    <= 1'b0;
            o_redirect <= 1'b0;
            o_ctrl_we  <= 1'b0;
            o_busy     <= 1'b0;
`ifdef IRQ_DISPATCH_NESTED_EN
            depth      <= 2'd0;
            // NOTE: the stack is cleared on reset so a stale frame can never be popped into cause/epc.
            for (int i = 0; i < 2; i++) begin
                stk_cause[i] <= 2'd0;
                stk_epc[i]   <= '0;
            end
`endif
        end else begin
            o_stall    <= 1'b0;
            o_redirect <= 1'b0;
            o_ctrl_we  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    o_busy <= 1'b0;
                    if (req && i_boundary) begin
                        cause     <= req_cause;
                        epc       <= i_pc;
                        o_stall   <= 1'b1;
                        o_ctrl_we <= 1'b1;
                        state     <= ST_SAVE;
                    end
                end

                ST_SAVE: begin
                    o_stall    <= 1'b1;
                    o_redirect <= 1'b1;
                    state      <= ST_VECTOR;
                end

                ST_VECTOR: begin
                    o_busy <= 1'b1;
                    state  <= ST_HANDLER;
                end

                ST_HANDLER: begin
                    if (i_eret) begin
                        o_redirect <= 1'b1;
                        state      <= ST_RETURN;
                    end
`ifdef IRQ_DISPATCH_NESTED_EN
                    else if (req && i_boundary && (req_cause > cause) && (depth != 2'd2)) begin
                        stk_cause[push_idx] <= cause;
                        stk_epc[push_idx]   <= epc;
                        depth               <= depth + 2'd1;
                        cause               <= req_cause;
                        epc                 <= i_pc;
                        o_stall             <= 1'b1;
                        o_ctrl_we           <= 1'b1;
                        state               <= ST_SAVE;
                    end
`endif
                end

                ST_RETURN: begin
`ifdef IRQ_DISPATCH_NESTED_EN
                    if (depth != 2'd0) begin
                        cause <= stk_cause[pop_idx];
                        epc   <= stk_epc[pop_idx];
                        depth <= depth - 2'd1;
                        state <= ST_HANDLER;
                    end else
`endif
                    begin
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_dispatch.sv
// Self-checking bench for irq_dispatch: vector table, hand-written corner sequences, randomized run vs. a timeline model.
// Nested-preemption sequence is compiled in when IRQ_DISPATCH_NESTED_EN is defined.

module tb_irq_dispatch;

    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic [31:0] i_ctrl;
    logic [31:0] i_pc;
    logic        i_boundary;
    logic        i_eret;
    logic        o_stall;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_ctrl_we;
    logic [31:0] o_ctrl_data;
    logic [1:0]  o_cause;
    logic [31:0] o_epc;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    irq_dispatch dut (
        .i_clk         (i_clk),
        .i_nrst        (i_nrst),
        .i_ctrl        (i_ctrl),
        .i_pc          (i_pc),
        .i_boundary    (i_boundary),
        .i_eret        (i_eret),
        .o_stall       (o_stall),
        .o_redirect    (o_redirect),
        .o_redirect_pc (o_redirect_pc),
        .o_ctrl_we     (o_ctrl_we),
        .o_ctrl_data   (o_ctrl_data),
        .o_cause       (o_cause),
        .o_epc         (o_epc),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] pc;
        bit          take;
        logic [1:0]  cause;
        logic [31:0] wb;
        logic [31:0] vec;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [127:0] pk(input logic st, input logic rd, input logic [31:0] rpc,
                                        input logic we, input logic [31:0] d, input logic [1:0] c,
                                        input logic [31:0] e, input logic bz);
        return {26'd0, st, rd, rpc, we, d, c, e, bz};
    endfunction

    function automatic logic [127:0] dut_out();
        return pk(o_stall, o_redirect, o_redirect_pc, o_ctrl_we, o_ctrl_data, o_cause, o_epc, o_busy);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] ctrl, input logic [31:0] pc, input logic bnd, input logic eret);
        i_ctrl     = ctrl;
        i_pc       = pc;
        i_boundary = bnd;
        i_eret     = eret;
    endtask

    task automatic do_reset();
        i_nrst = 1'b0;
        set_in(32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        i_nrst = 1'b1;
    endtask

    // Reference model: spec rules computed arithmetically; 'age' counts phases since the take.
    function automatic bit m_req(input logic [31:0] c);
        return c[15] && ((c[11:8] & c[3:0]) != 4'd0);
    endfunction

    function automatic logic [1:0] m_cause_of(input logic [31:0] c);
        logic [1:0] r = 2'd0;
        for (int i = 0; i < 4; i++)
            if (c[8+i] && c[i]) r = 2'(i);
        return r;
    endfunction

    function automatic logic [31:0] m_wb(input logic [31:0] c, input logic [1:0] cs);
        return c & ~(32'h8000 | (32'h100 << cs));
    endfunction

    function automatic logic [31:0] m_vec(input logic [1:0] cs);
        return 32'h180 + 32'(cs) * 32'd16;
    endfunction

    initial begin
        logic [1:0]  last_cause;
        logic [31:0] last_epc;
        int          age;
        logic [1:0]  mc;
        logic [31:0] me;
        logic [31:0] r;
        logic [127:0] exp_v;

        tbl[0] = '{32'h0000_8103, 32'h40,  1'b1, 2'd0, 32'h0000_0003, 32'h180};
        tbl[1] = '{32'h0000_8F0A, 32'h100, 1'b1, 2'd3, 32'h0000_070A, 32'h1B0};
        tbl[2] = '{32'h0000_8F00, 32'h0,   1'b0, 2'd0, 32'h0,         32'h0};
        tbl[3] = '{32'h0000_0F0F, 32'h0,   1'b0, 2'd0, 32'h0,         32'h0};
        tbl[4] = '{32'h0000_8605, 32'h200, 1'b1, 2'd2, 32'h0000_0205, 32'h1A0};
        tbl[5] = '{32'hABCD_8203, 32'h3FC, 1'b1, 2'd1, 32'hABCD_0003, 32'h190};
        tbl[6] = '{32'h0000_8E01, 32'h0,   1'b0, 2'd0, 32'h0,         32'h0};

        do_reset();
        check("reset state", dut_out(), 128'd0);

        // Table-driven takes and non-takes from IDLE.
        last_cause = 2'd0;
        last_epc   = 32'h0;
        for (int i = 0; i < 7; i++) begin
            set_in(tbl[i].ctrl, tbl[i].pc, 1'b1, 1'b0);
            if (tbl[i].take) begin
                tick();
                check($sformatf("tbl%0d save", i), dut_out(),
                      pk(1, 0, 0, 1, tbl[i].wb, tbl[i].cause, tbl[i].pc, 0));
                i_boundary = 1'b0;
                tick();
                check($sformatf("tbl%0d vector", i), dut_out(),
                      pk(1, 1, tbl[i].vec, 0, 0, tbl[i].cause, tbl[i].pc, 0));
                tick();
                check($sformatf("tbl%0d handler", i), dut_out(),
                      pk(0, 0, 0, 0, 0, tbl[i].cause, tbl[i].pc, 1));
                i_eret = 1'b1;
                tick();
                check($sformatf("tbl%0d return", i), dut_out(),
                      pk(0, 1, tbl[i].pc, 0, 0, tbl[i].cause, tbl[i].pc, 1));
                i_eret = 1'b0;
                tick();
                check($sformatf("tbl%0d idle", i), dut_out(),
                      pk(0, 0, 0, 0, 0, tbl[i].cause, tbl[i].pc, 0));
                last_cause = tbl[i].cause;
                last_epc   = tbl[i].pc;
            end else begin
                for (int k = 0; k < 10; k++) begin
                    tick();
                    check($sformatf("tbl%0d no take", i), dut_out(),
                          pk(0, 0, 0, 0, 0, last_cause, last_epc, 0));
                end
            end
        end

        // New request during HANDLER together with ERET: return first, take later.
        do_reset();
        set_in(32'h8103, 32'h40, 1'b1, 1'b0);
        tick();
        i_boundary = 1'b0;
        tick();
        tick();
        set_in(32'h8F0A, 32'h40, 1'b1, 1'b0);
        tick();
        check("handler ignores req", dut_out(), pk(0, 0, 0, 0, 0, 0, 32'h40, 1));
        i_eret = 1'b1;
        tick();
        check("eret return", dut_out(), pk(0, 1, 32'h40, 0, 0, 0, 32'h40, 1));
        i_eret = 1'b0;
        tick();
        check("return to idle", dut_out(), pk(0, 0, 0, 0, 0, 0, 32'h40, 0));
        tick();
        check("take after return", dut_out(), pk(1, 0, 0, 1, 32'h070A, 3, 32'h40, 0));

        // ERET in IDLE does nothing.
        do_reset();
        set_in(32'h0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("eret in idle", dut_out(), 128'd0);
        end

        // Request waits for a boundary; a request that drops first is never taken.
        set_in(32'h8103, 32'h80, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("req waits", dut_out(), 128'd0);
        end
        set_in(32'h0, 32'h80, 1'b1, 1'b0);
        tick();
        check("dropped req", dut_out(), 128'd0);
        set_in(32'h8103, 32'h84, 1'b1, 1'b0);
        tick();
        check("late boundary take", dut_out(), pk(1, 0, 0, 1, 32'h3, 0, 32'h84, 0));

        // Reset asserted during VECTOR.
        do_reset();
        set_in(32'h8F0A, 32'h80, 1'b1, 1'b0);
        tick();
        i_boundary = 1'b0;
        tick();
        check("pre-reset vector", dut_out(), pk(1, 1, 32'h1B0, 0, 0, 3, 32'h80, 0));
        i_nrst = 1'b0;
        tick();
        check("reset in vector", dut_out(), 128'd0);
        i_nrst = 1'b1;
        set_in(32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check("idle after reset", dut_out(), 128'd0);
        set_in(32'h8103, 32'h44, 1'b1, 1'b0);
        tick();
        check("take after reset", dut_out(), pk(1, 0, 0, 1, 32'h3, 0, 32'h44, 0));

`ifdef IRQ_DISPATCH_NESTED_EN
        // Nested: cause 1 preempted by cause 2, cause 0 refused, two ERETs unwind.
        do_reset();
        set_in(32'h8202, 32'h40, 1'b1, 1'b0);
        tick();
        i_boundary = 1'b0;
        tick();
        tick();
        set_in(32'h8404, 32'h300, 1'b1, 1'b0);
        tick();
        check("nest save", {o_stall, o_ctrl_we, o_ctrl_data, o_cause, o_epc},
              {1'b1, 1'b1, 32'h0004, 2'd2, 32'h300});
        i_boundary = 1'b0;
        tick();
        check("nest vector", {o_redirect, o_redirect_pc}, {1'b1, 32'h1A0});
        tick();
        set_in(32'h8101, 32'h500, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("nest lower refused", {o_stall, o_ctrl_we, o_busy}, 3'b001);
        end
        set_in(32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        check("nest ret1", {o_redirect, o_redirect_pc}, {1'b1, 32'h300});
        i_eret = 1'b0;
        tick();
        check("nest pop", {o_busy, o_cause, o_epc}, {1'b1, 2'd1, 32'h40});
        i_eret = 1'b1;
        tick();
        check("nest ret2", {o_redirect, o_redirect_pc}, {1'b1, 32'h40});
        i_eret = 1'b0;
        tick();
        check("nest idle", {o_busy, o_redirect}, 2'b00);
`endif

        // Randomized run against the timeline model.
        do_reset();
        age = 0;
        mc  = 2'd0;
        me  = 32'h0;
        for (int n = 0; n < 400; n++) begin
            r     = $urandom;
            r[15] = ($urandom_range(0, 3) != 0);
            i_ctrl     = r;
            i_pc       = $urandom & 32'hFFFF_FFFC;
            i_boundary = $urandom_range(0, 1) == 1;
            i_eret     = $urandom_range(0, 3) == 0;
            i_nrst     = $urandom_range(0, 49) != 0;
`ifdef IRQ_DISPATCH_NESTED_EN
            if (age == 3) i_boundary = 1'b0;
`endif
            tick();
            if (!i_nrst) begin
                age = 0;
                mc  = 2'd0;
                me  = 32'h0;
            end else begin
                case (age)
                    0: if (m_req(i_ctrl) && i_boundary) begin
                           mc  = m_cause_of(i_ctrl);
                           me  = i_pc;
                           age = 1;
                       end
                    1: age = 2;
                    2: age = 3;
                    3: if (i_eret) age = 4;
                    default: age = 0;
                endcase
            end
            case (age)
                1:       exp_v = pk(1, 0, 0, 1, m_wb(i_ctrl, mc), mc, me, 0);
                2:       exp_v = pk(1, 1, m_vec(mc), 0, 0, mc, me, 0);
                3:       exp_v = pk(0, 0, 0, 0, 0, mc, me, 1);
                4:       exp_v = pk(0, 1, me, 0, 0, mc, me, 1);
                default: exp_v = pk(0, 0, 0, 0, 0, mc, me, 0);
            endcase
            check($sformatf("rand cycle %0d", n), dut_out(), exp_v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
